// File: rtl/rv_trace_pkg.sv
// Shared encodings for the retirement trace monitor: capture modes, halt opcode, flag layout.
// Build option RV_TRACE_PERF_EN (see rv_trace_monitor) uses sat_inc.
package rv_trace_pkg;

  typedef enum logic [1:0] {
    CAP_ALL = 2'b00,
    CAP_BRJ = 2'b01,
    CAP_OFF = 2'b10
  } cap_mode_e;

  localparam logic [31:0] HALT_INSTR = 32'h0000006F;

  localparam int FLAG_BR  = 0;
  localparam int FLAG_JMP = 1;
  localparam int FLAG_W   = 2;

  // 2'b11 is treated as off as well.
  function automatic logic cap_qualify(input logic [1:0] mode, input logic br, input logic jmp);
    return (mode == CAP_ALL) || ((mode == CAP_BRJ) && (br || jmp));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/rv_trace_fifo.sv
// Ring buffer with overwrite-oldest or drop-newest policy when full; pop data registered (1 cycle).
// Never stalls the writer: a full write either evicts the oldest entry or is dropped, and sets overflow.
module rv_trace_fifo #(
  parameter int DW        = 66,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_dat,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          full, do_pop, evict, do_wr, lost, adv_rd;

  always_comb begin
    full   = (count == FULL_CNT);
    do_pop = rd_en && (count != '0);
    // Evicting: write slot equals read slot when full, so the oldest is replaced in place.
    evict  = wr_en && full && !do_pop && (OVERWRITE != 0);
    do_wr  = wr_en && (!full || do_pop || evict);
    lost   = wr_en && full && !do_pop;
    adv_rd = do_pop || evict;
    count_nxt = count;
    case ({do_wr, adv_rd})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      rd_dat   <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) rd_dat <= mem[rd_ptr];
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (lost) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rv_trace_monitor.sv
// Retire-trace capture, watchdog and end-of-program detect; entry visible in count 1 cycle after retire.
// Retire side never backpressured (full -> overwrite/drop); pops return data 1 cycle later. Option: RV_TRACE_PERF_EN.
module rv_trace_monitor
  import rv_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int WD_CYCLES = 10000,
  parameter int OVERWRITE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   retire_valid,
  input  logic [XLEN-1:0]        retire_pc,
  input  logic [31:0]            retire_instr,
  input  logic                   retire_branch,
  input  logic                   retire_jump,
  input  logic [1:0]             capture_mode,
  input  logic                   clear,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [XLEN-1:0]        rd_pc,
  output logic [31:0]            rd_instr,
  output logic [1:0]             rd_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   wd_timeout,
  output logic                   halted
`ifdef RV_TRACE_PERF_EN
  ,
  output logic [31:0]            cyc_cnt,
  output logic [31:0]            ret_cnt,
  output logic [31:0]            br_cnt,
  output logic [31:0]            jmp_cnt
`endif
);

  localparam int DW = XLEN + 32 + FLAG_W;

  logic [DW-1:0]     wr_dat, rd_dat;
  logic [FLAG_W-1:0] flags_in;
  logic              capture, halt_hit;

  always_comb begin
    flags_in           = '0;
    flags_in[FLAG_BR]  = retire_branch;
    flags_in[FLAG_JMP] = retire_jump;
    wr_dat   = {flags_in, retire_instr, retire_pc};
    capture  = retire_valid && !halted && cap_qualify(capture_mode, retire_branch, retire_jump);
    halt_hit = retire_valid && !halted && (retire_instr == HALT_INSTR);
  end

  assign {rd_flags, rd_instr, rd_pc} = rd_dat;

  rv_trace_fifo #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_en    (capture),
    .wr_dat   (wr_dat),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_dat   (rd_dat),
    .count    (count),
    .overflow (overflow)
  );

  // The self-loop jal is itself captured (capture uses the pre-update halted).
  always_ff @(posedge clk) begin
    if (!rst_n || clear) halted <= 1'b0;
    else if (halt_hit)   halted <= 1'b1;
  end

  generate
    if (WD_CYCLES > 0) begin : g_wd
      localparam logic [31:0] WD_LIM = 32'(WD_CYCLES);
      logic [31:0] wd_cnt;
      always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
          wd_cnt     <= '0;
          wd_timeout <= 1'b0;
        end else if (!halted) begin
          if (retire_valid) begin
            wd_cnt <= '0;
          end else if (wd_cnt != WD_LIM) begin
            wd_cnt <= wd_cnt + 32'd1;
            if (wd_cnt == WD_LIM - 32'd1) wd_timeout <= 1'b1;
          end
        end
      end
    end else begin : g_no_wd
      assign wd_timeout = 1'b0;
    end
  endgenerate

`ifdef RV_TRACE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
      br_cnt  <= '0;
      jmp_cnt <= '0;
    end else begin
      cyc_cnt <= sat_inc(cyc_cnt, !halted);
      ret_cnt <= sat_inc(ret_cnt, retire_valid);
      br_cnt  <= sat_inc(br_cnt, retire_valid && retire_branch);
      jmp_cnt <= sat_inc(jmp_cnt, retire_valid && retire_jump);
    end
  end
`endif

endmodule

// File: tb/tb_rv_trace_monitor.sv
// Directed bench for rv_trace_monitor: a DEPTH=16 instance driven from a vector table, plus
// DEPTH=4 overwrite/drop instances for full-buffer, watchdog and halt sequences.
module tb_rv_trace_monitor;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, retire_valid, retire_branch, retire_jump, clear, rd_en;
  logic [31:0] retire_pc, retire_instr;
  logic [1:0]  capture_mode;

  logic        a_rdv, b_rdv, c_rdv;
  logic [31:0] a_pc, b_pc, c_pc, a_instr, b_instr, c_instr;
  logic [1:0]  a_flg, b_flg, c_flg;
  logic [4:0]  a_cnt;
  logic [2:0]  b_cnt, c_cnt;
  logic        a_ovf, b_ovf, c_ovf, a_wd, b_wd, c_wd, a_hlt, b_hlt, c_hlt;
`ifdef RV_TRACE_PERF_EN
  logic [31:0] a_cyc, a_ret, a_br, a_jmp, b_cyc, b_ret, b_br, b_jmp, c_cyc, c_ret, c_br, c_jmp;
`endif

  rv_trace_monitor #(.XLEN(32), .DEPTH(16), .WD_CYCLES(20), .OVERWRITE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_branch(retire_branch), .retire_jump(retire_jump),
    .capture_mode(capture_mode), .clear(clear), .rd_en(rd_en), .rd_valid(a_rdv), .rd_pc(a_pc),
    .rd_instr(a_instr), .rd_flags(a_flg), .count(a_cnt), .overflow(a_ovf), .wd_timeout(a_wd),
    .halted(a_hlt)
`ifdef RV_TRACE_PERF_EN
    , .cyc_cnt(a_cyc), .ret_cnt(a_ret), .br_cnt(a_br), .jmp_cnt(a_jmp)
`endif
  );

  rv_trace_monitor #(.XLEN(32), .DEPTH(4), .WD_CYCLES(20), .OVERWRITE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_branch(retire_branch), .retire_jump(retire_jump),
    .capture_mode(capture_mode), .clear(clear), .rd_en(rd_en), .rd_valid(b_rdv), .rd_pc(b_pc),
    .rd_instr(b_instr), .rd_flags(b_flg), .count(b_cnt), .overflow(b_ovf), .wd_timeout(b_wd),
    .halted(b_hlt)
`ifdef RV_TRACE_PERF_EN
    , .cyc_cnt(b_cyc), .ret_cnt(b_ret), .br_cnt(b_br), .jmp_cnt(b_jmp)
`endif
  );

  rv_trace_monitor #(.XLEN(32), .DEPTH(4), .WD_CYCLES(0), .OVERWRITE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_branch(retire_branch), .retire_jump(retire_jump),
    .capture_mode(capture_mode), .clear(clear), .rd_en(rd_en), .rd_valid(c_rdv), .rd_pc(c_pc),
    .rd_instr(c_instr), .rd_flags(c_flg), .count(c_cnt), .overflow(c_ovf), .wd_timeout(c_wd),
    .halted(c_hlt)
`ifdef RV_TRACE_PERF_EN
    , .cyc_cnt(c_cyc), .ret_cnt(c_ret), .br_cnt(c_br), .jmp_cnt(c_jmp)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        br;
    logic        jmp;
    logic [1:0]  mode;
    logic        rde;
    logic [4:0]  e_cnt;
    logic        e_rdv;
    logic [31:0] e_pc;
    logic [1:0]  e_flg;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input int rv, input int pc, input int br, input int jmp, input int mode,
                              input int rde, input int cnt, input int rdv, input int epc, input int flg);
    vec_t r;
    r.rv = 1'(rv);   r.pc = 32'(pc);   r.br = 1'(br);     r.jmp = 1'(jmp);  r.mode = 2'(mode);
    r.rde = 1'(rde); r.e_cnt = 5'(cnt); r.e_rdv = 1'(rdv); r.e_pc = 32'(epc); r.e_flg = 2'(flg);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    retire_valid = 1'b0; retire_branch = 1'b0; retire_jump = 1'b0;
    rd_en = 1'b0; clear = 1'b0; retire_instr = NOP;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    retire_valid = 1'b1; retire_pc = pc; retire_instr = instr;
    retire_branch = 1'b0; retire_jump = 1'b0; rd_en = 1'b0;
    step();
    idle();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    idle();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    idle();
  endtask

  initial begin
    //          rv pc    br jm md rd | cnt rdv pc    flg
    tv[0]  = mk(1, 'h00, 0, 0, 0, 0,   1, 0, 'h00, 0);
    tv[1]  = mk(1, 'h04, 0, 0, 0, 0,   2, 0, 'h00, 0);
    tv[2]  = mk(1, 'h08, 0, 0, 0, 0,   3, 0, 'h00, 0);
    tv[3]  = mk(1, 'h0C, 0, 0, 0, 0,   4, 0, 'h00, 0);
    tv[4]  = mk(1, 'h10, 0, 0, 0, 0,   5, 0, 'h00, 0);
    tv[5]  = mk(0, 'h00, 0, 0, 0, 1,   4, 1, 'h00, 0);
    tv[6]  = mk(0, 'h00, 0, 0, 0, 1,   3, 1, 'h04, 0);
    tv[7]  = mk(0, 'h00, 0, 0, 0, 1,   2, 1, 'h08, 0);
    tv[8]  = mk(0, 'h00, 0, 0, 0, 1,   1, 1, 'h0C, 0);
    tv[9]  = mk(0, 'h00, 0, 0, 0, 1,   0, 1, 'h10, 0);
    tv[10] = mk(0, 'h00, 0, 0, 0, 1,   0, 0, 'h10, 0);
    tv[11] = mk(1, 'h00, 0, 0, 1, 0,   0, 0, 'h10, 0);
    tv[12] = mk(1, 'h04, 0, 0, 1, 0,   0, 0, 'h10, 0);
    tv[13] = mk(1, 'h08, 1, 0, 1, 0,   1, 0, 'h10, 0);
    tv[14] = mk(1, 'h0C, 0, 0, 1, 0,   1, 0, 'h10, 0);
    tv[15] = mk(1, 'h10, 0, 0, 1, 0,   1, 0, 'h10, 0);
    tv[16] = mk(1, 'h14, 0, 1, 1, 0,   2, 0, 'h10, 0);
    tv[17] = mk(0, 'h00, 0, 0, 1, 1,   1, 1, 'h08, 1);
    tv[18] = mk(0, 'h00, 0, 0, 1, 1,   0, 1, 'h14, 2);
    tv[19] = mk(1, 'h18, 1, 0, 2, 0,   0, 0, 'h14, 2);
    tv[20] = mk(1, 'h1C, 0, 1, 3, 0,   0, 0, 'h14, 2);
    tv[21] = mk(1, 'h20, 0, 0, 0, 0,   1, 0, 'h14, 2);
    tv[22] = mk(1, 'h24, 0, 0, 0, 1,   1, 1, 'h20, 0);
    tv[23] = mk(0, 'h00, 0, 0, 0, 1,   0, 1, 'h24, 0);

    rst_n = 1'b0; capture_mode = 2'b00; retire_pc = '0;
    idle();
    step();
    step();
    chk("reset count",    32'(a_cnt), 0);
    chk("reset rd_valid", 32'(a_rdv), 0);
    chk("reset rd_pc",    a_pc, 0);
    chk("reset rd_flags", 32'(a_flg), 0);
    chk("reset overflow", 32'(a_ovf), 0);
    chk("reset wd",       32'(a_wd), 0);
    chk("reset halted",   32'(a_hlt), 0);
    chk("reset b count",  32'(b_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      retire_valid = tv[i].rv; retire_pc = tv[i].pc; retire_instr = NOP;
      retire_branch = tv[i].br; retire_jump = tv[i].jmp;
      capture_mode = tv[i].mode; rd_en = tv[i].rde;
      step();
      chk($sformatf("v%0d count", i),    32'(a_cnt), 32'(tv[i].e_cnt));
      chk($sformatf("v%0d rd_valid", i), 32'(a_rdv), 32'(tv[i].e_rdv));
      chk($sformatf("v%0d rd_pc", i),    a_pc, tv[i].e_pc);
      chk($sformatf("v%0d rd_flags", i), 32'(a_flg), 32'(tv[i].e_flg));
      if (tv[i].e_rdv) chk($sformatf("v%0d rd_instr", i), a_instr, NOP);
    end
    idle();
    capture_mode = 2'b00;

    // clear flushes state but rd_* data holds
    do_clear();
    chk("clr rd_valid", 32'(a_rdv), 0);
    chk("clr rd_pc hold", a_pc, 32'h24);
    chk("clr count", 32'(a_cnt), 0);

    // full buffer: overwrite (u_b) vs drop (u_c)
    for (int k = 0; k < 6; k++) retire(32'(4 * k), NOP);
    chk("ovw count", 32'(b_cnt), 4);
    chk("ovw overflow", 32'(b_ovf), 1);
    chk("drop count", 32'(c_cnt), 4);
    chk("drop overflow", 32'(c_ovf), 1);
    chk("deep overflow", 32'(a_ovf), 0);
    pop();
    chk("ovw first pop", b_pc, 32'h08);
    chk("ovw rd_valid", 32'(b_rdv), 1);
    chk("drop first pop", c_pc, 32'h00);
    chk("ovw count after pop", 32'(b_cnt), 3);
    pop();
    chk("ovw second pop", b_pc, 32'h0C);
    chk("drop second pop", c_pc, 32'h04);

    // full buffer with simultaneous write and pop
    do_clear();
    for (int k = 0; k < 4; k++) retire(32'h100 + 32'(4 * k), NOP);
    chk("full b count", 32'(b_cnt), 4);
    chk("full b overflow", 32'(b_ovf), 0);
    retire_valid = 1'b1; retire_pc = 32'h110; rd_en = 1'b1;
    step();
    idle();
    chk("wr+pop b count", 32'(b_cnt), 4);
    chk("wr+pop c count", 32'(c_cnt), 4);
    chk("wr+pop b overflow", 32'(b_ovf), 0);
    chk("wr+pop c overflow", 32'(c_ovf), 0);
    chk("wr+pop b pc", b_pc, 32'h100);
    chk("wr+pop c pc", c_pc, 32'h100);
    for (int k = 1; k <= 4; k++) begin
      pop();
      chk($sformatf("drain b %0d", k), b_pc, 32'h100 + 32'(4 * k));
      chk($sformatf("drain c %0d", k), c_pc, 32'h100 + 32'(4 * k));
    end

    // watchdog
    do_clear();
    repeat (19) step();
    chk("wd at 19", 32'(a_wd), 0);
    step();
    chk("wd at 20", 32'(a_wd), 1);
    chk("wd b at 20", 32'(b_wd), 1);
    chk("wd disabled", 32'(c_wd), 0);
    repeat (5) step();
    chk("wd sticky", 32'(a_wd), 1);
    do_clear();
    chk("wd cleared", 32'(a_wd), 0);
    repeat (18) step();
    retire_valid = 1'b1; retire_pc = 32'h200;
    step();
    idle();
    chk("wd kicked at 20", 32'(a_wd), 0);
    repeat (15) step();
    chk("wd kicked later", 32'(a_wd), 0);

    // halt
    do_clear();
    retire(32'h3C, NOP);
    retire(32'h40, 32'h0000_006F);
    chk("halted set", 32'(a_hlt), 1);
    chk("halt count", 32'(a_cnt), 2);
    retire(32'h44, NOP);
    retire(32'h48, NOP);
    chk("halt count frozen", 32'(a_cnt), 2);
    repeat (25) step();
    chk("wd idle when halted", 32'(a_wd), 0);
    pop();
    chk("halt pop 1", a_pc, 32'h3C);
    pop();
    chk("halt last pc", a_pc, 32'h40);
    chk("halt last instr", a_instr, 32'h0000_006F);
    chk("halt drained", 32'(a_cnt), 0);
    do_clear();
    chk("halt cleared", 32'(a_hlt), 0);
    chk("post clear count", 32'(a_cnt), 0);
    chk("post clear overflow", 32'(b_ovf), 0);
    retire(32'h50, NOP);
    chk("capture resumes", 32'(a_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
